// File: rtl/wave_voice_scheduler_if.sv
// wave_voice_scheduler_if
//   Bundles every non-clock/reset signal of the voice scheduler:
//   host configuration bus, sync/tick strobes, the request/return
//   handshake to the shared sine/amplitude datapath, and the sample output.
//   Modports:
//     slave  - the scheduler itself
//     master - its environment (host, datapath, sample consumer)
//   Datapath handshake: a request is transferred in every cycle that
//   dp_valid=1 (the datapath has no ready and must accept one request per
//   cycle); each request yields exactly one later cycle with dp_rvalid=1
//   carrying dp_result, in issue order.
//   dbg_state exposes the scheduler FSM state (0 IDLE, 1 ISSUE, 2 DRAIN, 3 DONE).
interface wave_voice_scheduler_if #(
  parameter int NCH = 8
);
  localparam int CW = $clog2(NCH);

  logic          cfg_we;
  logic [CW-1:0] cfg_addr;
  logic [1:0]    cfg_sel;
  logic [15:0]   cfg_data;
  logic          sync;
  logic          sample_tick;
  logic          dp_valid;
  logic [11:0]   dp_phase;
  logic [15:0]   dp_amp;
  logic          dp_rvalid;
  logic [15:0]   dp_result;
  logic [15:0]   sample;
  logic          sample_valid;
  logic          busy;
  logic          overrun;
  logic [1:0]    dbg_state;

  modport slave (
    input  cfg_we, cfg_addr, cfg_sel, cfg_data, sync, sample_tick,
    input  dp_rvalid, dp_result,
    output dp_valid, dp_phase, dp_amp,
    output sample, sample_valid, busy, overrun, dbg_state
  );

  modport master (
    output cfg_we, cfg_addr, cfg_sel, cfg_data, sync, sample_tick,
    output dp_rvalid, dp_result,
    input  dp_valid, dp_phase, dp_amp,
    input  sample, sample_valid, busy, overrun, dbg_state
  );
endinterface

// File: rtl/wave_voice_scheduler.sv
// wave_voice_scheduler
//   Time-multiplexes one shared sine/amplitude datapath across NCH voices.
//   On each accepted sample_tick it issues one (phase, amp) request per cycle
//   for voices 0..NCH-1, sums the NCH returned products and emits one
//   saturated signed 16-bit sample.
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous, active-high; clears all state
//     bus   - wave_voice_scheduler_if.slave (config bus, sync/tick strobes,
//             datapath request/return, sample, busy, overrun, dbg_state)
//   Optional feature: define WAVESEQ_MUTE_EN to add a per-voice mute
//   register (cfg_sel=3, cfg_data[0]); a muted voice is still issued and
//   its phase still advances, only its dp_amp is forced to 0.
module wave_voice_scheduler #(
  parameter int NCH = 8
) (
  input logic                   clk,
  input logic                   reset,
  wave_voice_scheduler_if.slave bus
);
  localparam int CW = $clog2(NCH);
  localparam int SW = 16 + CW;
  localparam logic [CW:0]   NCH_CNT  = (CW+1)'(NCH);
  localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_next;

  logic [15:0]   r_amp   [NCH];
  logic [15:0]   r_phoff [NCH];
  logic [15:0]   r_phadd [NCH];
  logic [15:0]   r_acc   [NCH];
  logic [CW-1:0] r_idx;
  logic [CW:0]   r_ret_cnt;
  logic [SW-1:0] r_sum;
  logic          r_sweep_sync;
  logic          r_sync_pend;
  logic [15:0]   r_sample;
  logic          r_sample_valid;
  logic          r_dp_valid;
  logic [11:0]   r_dp_phase;
  logic [15:0]   r_dp_amp;
  logic          r_overrun;
`ifdef WAVESEQ_MUTE_EN
  logic [NCH-1:0] r_mute;
`endif

  logic          w_start;
  logic          w_issue;
  logic [CW-1:0] w_issue_idx;
  logic          w_issue_sync;
  logic [15:0]   w_issue_base;
  logic [15:0]   w_issue_amp;
  logic          w_ret_take;
  logic [SW-1:0] w_sum_next;
  logic [CW:0]   w_cnt_next;
  logic          w_all_back;
  logic [15:0]   w_sat;

  assign w_start = (r_state == S_IDLE) && bus.sample_tick;

  // Return path: returns are counted only inside a sweep and only up to NCH.
  always_comb begin
    w_ret_take = bus.dp_rvalid && (r_state != S_IDLE) && (r_ret_cnt != NCH_CNT);
    w_sum_next = r_sum;
    w_cnt_next = r_ret_cnt;
    if (w_ret_take) begin
      w_sum_next = r_sum + {{CW{bus.dp_result[15]}}, bus.dp_result};
      w_cnt_next = r_ret_cnt + 1'b1;
    end
    w_all_back = (w_cnt_next == NCH_CNT);
  end

  // The sum fits in 16 bits iff every bit above bit 15 equals the sign bit.
  always_comb begin
    if (w_sum_next[SW-1:15] == {(CW+1){w_sum_next[SW-1]}}) w_sat = w_sum_next[15:0];
    else if (w_sum_next[SW-1])                             w_sat = 16'h8000;
    else                                                   w_sat = 16'h7FFF;
  end

  // Next-state logic. Request registers are loaded one edge ahead, so the
  // voice issued at an edge is the one shown on dp_* in the following cycle.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_issue_idx  = '0;
    w_issue_sync = r_sweep_sync;
    case (r_state)
      S_IDLE: begin
        if (bus.sample_tick) begin
          w_state_next = S_ISSUE;
          w_issue      = 1'b1;
          w_issue_sync = r_sync_pend;
        end
      end
      S_ISSUE: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = w_all_back ? S_DONE : S_DRAIN;
        end else begin
          w_issue     = 1'b1;
          w_issue_idx = r_idx + 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_all_back) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue_base = w_issue_sync ? r_phoff[w_issue_idx] : r_acc[w_issue_idx];
`ifdef WAVESEQ_MUTE_EN
    w_issue_amp = r_mute[w_issue_idx] ? 16'h0000 : r_amp[w_issue_idx];
`else
    w_issue_amp = r_amp[w_issue_idx];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        r_amp[i]   <= '0;
        r_phoff[i] <= '0;
        r_phadd[i] <= '0;
      end
    end else if (bus.cfg_we) begin
      case (bus.cfg_sel)
        2'd0:    r_amp[bus.cfg_addr]   <= bus.cfg_data;
        2'd1:    r_phoff[bus.cfg_addr] <= bus.cfg_data;
        2'd2:    r_phadd[bus.cfg_addr] <= bus.cfg_data;
        default: ;
      endcase
    end
  end

`ifdef WAVESEQ_MUTE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_mute <= '0;
    else if (bus.cfg_we && (bus.cfg_sel == 2'd3)) r_mute[bus.cfg_addr] <= bus.cfg_data[0];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
    end else if (w_issue) begin
      r_acc[w_issue_idx] <= w_issue_base + r_phadd[w_issue_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_ret_cnt    <= '0;
      r_sum        <= '0;
      r_sweep_sync <= 1'b0;
      r_sync_pend  <= 1'b0;
    end else begin
      if (w_start) begin
        r_sum        <= '0;
        r_ret_cnt    <= '0;
        r_sweep_sync <= r_sync_pend;
      end else begin
        r_sum     <= w_sum_next;
        r_ret_cnt <= w_cnt_next;
      end
      if (w_issue) r_idx <= w_issue_idx;
      // A sync arriving in the very cycle a sweep starts stays pending.
      if (bus.sync)     r_sync_pend <= 1'b1;
      else if (w_start) r_sync_pend <= 1'b0;
    end
  end

  // The sample is captured on the edge that enters DONE, so sample_valid is
  // high during the DONE cycle with the new sample already visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dp_valid     <= 1'b0;
      r_dp_phase     <= '0;
      r_dp_amp       <= '0;
      r_overrun      <= 1'b0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_dp_valid     <= w_issue;
      r_dp_phase     <= w_issue ? w_issue_base[15:4] : 12'h000;
      r_dp_amp       <= w_issue ? w_issue_amp : 16'h0000;
      r_overrun      <= bus.sample_tick && (r_state != S_IDLE);
      r_sample_valid <= (w_state_next == S_DONE);
      if (w_state_next == S_DONE) r_sample <= w_sat;
    end
  end

  assign bus.dp_valid     = r_dp_valid;
  assign bus.dp_phase     = r_dp_phase;
  assign bus.dp_amp       = r_dp_amp;
  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_sample_valid;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.overrun      = r_overrun;
  assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_wave_voice_scheduler.sv
// tb_wave_voice_scheduler
//   Bench for wave_voice_scheduler (NCH=8) with a 1-cycle loopback datapath
//   returning amp*sin(phase). A reference model of the voice registers
//   predicts each sweep's requests and sample when the tick is driven;
//   step() compares DUT requests and samples against those queues.
module tb_wave_voice_scheduler;
  localparam int NCH = 8;
  localparam int CW  = $clog2(NCH);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wave_voice_scheduler_if #(.NCH(NCH)) bus ();
  wave_voice_scheduler #(.NCH(NCH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks  = 0;
  int n_errors  = 0;
  int n_samples = 0;

  logic [27:0] exp_q[$];    // {phase[11:0], amp[15:0]} per request
  logic [15:0] exp_s_q[$];  // expected samples

  logic [15:0] m_amp[NCH];
  logic [15:0] m_phoff[NCH];
  logic [15:0] m_phadd[NCH];
  logic [15:0] m_acc[NCH];
  logic        m_mute[NCH];
  logic        m_sync_pend;
  logic        force_mode = 1'b0;
  logic [15:0] force_val  = 16'h0000;

  function automatic logic [15:0] dp_func(input logic [11:0] ph, input logic [15:0] amp);
    real r;
    int  v;
    if (force_mode) return force_val;
    r = $itor($signed(amp)) * $sin(6.283185307179586 * $itor(ph) / 4096.0);
    v = $rtoi(r);
    return v[15:0];
  endfunction

  // 1-cycle datapath: a request seen in cycle k is answered in cycle k+1.
  logic        pend_v;
  logic [15:0] pend_r;
  always @(negedge clk) begin
    if (reset) begin
      pend_v        = 1'b0;
      pend_r        = 16'h0000;
      bus.dp_rvalid = 1'b0;
      bus.dp_result = 16'h0000;
    end else begin
      bus.dp_rvalid = pend_v;
      bus.dp_result = pend_r;
      pend_v        = bus.dp_valid;
      pend_r        = dp_func(bus.dp_phase, bus.dp_amp);
    end
  end

  // Advance one cycle: scoreboard compare at the falling edge, then return
  // 1 time unit after the next rising edge.
  task automatic step();
    logic [27:0] e;
    logic [15:0] es;
    @(negedge clk);
    if (!reset) begin
      if (bus.dp_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL dp_request: unexpected request phase=%h amp=%h", bus.dp_phase, bus.dp_amp);
        end else begin
          e = exp_q.pop_front();
          if ({bus.dp_phase, bus.dp_amp} !== e) begin
            n_errors++;
            $display("FAIL dp_request: got phase=%h amp=%h, want phase=%h amp=%h",
                     bus.dp_phase, bus.dp_amp, e[27:16], e[15:0]);
          end
        end
      end
      if (bus.sample_valid) begin
        n_checks++;
        n_samples++;
        if (exp_s_q.size() == 0) begin
          n_errors++;
          $display("FAIL sample: unexpected sample %h", bus.sample);
        end else begin
          es = exp_s_q.pop_front();
          if (bus.sample !== es) begin
            n_errors++;
            $display("FAIL sample: got %h, want %h", bus.sample, es);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_amp[i] = '0; m_phoff[i] = '0; m_phadd[i] = '0; m_acc[i] = '0; m_mute[i] = 1'b0;
    end
    m_sync_pend = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input int addr, input logic [15:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_addr = CW'(addr);
    bus.cfg_data = data;
    step();
    bus.cfg_we = 1'b0;
    case (sel)
      2'd0: m_amp[addr]   = data;
      2'd1: m_phoff[addr] = data;
      2'd2: m_phadd[addr] = data;
      default: begin
`ifdef WAVESEQ_MUTE_EN
        m_mute[addr] = data[0];
`endif
      end
    endcase
  endtask

  task automatic predict_sweep();
    logic [15:0] base, amp, res;
    int s;
    s = 0;
    for (int i = 0; i < NCH; i++) begin
      base = m_sync_pend ? m_phoff[i] : m_acc[i];
      amp  = m_mute[i] ? 16'h0000 : m_amp[i];
      exp_q.push_back({base[15:4], amp});
      res = dp_func(base[15:4], amp);
      s += $signed(res);
      m_acc[i] = base + m_phadd[i];
    end
    m_sync_pend = 1'b0;
    if (s > 32767)       exp_s_q.push_back(16'h7FFF);
    else if (s < -32768) exp_s_q.push_back(16'h8000);
    else                 exp_s_q.push_back(s[15:0]);
  endtask

  // Drives the tick in cycle T; returns in cycle T+1.
  task automatic start_sweep();
    bus.sample_tick = 1'b1;
    predict_sweep();
    step();
    bus.sample_tick = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (n_samples < target && t < 60) begin
      step();
      t++;
    end
    n_checks++;
    if (n_samples < target) begin
      n_errors++;
      $display("FAIL sweep_timeout: samples=%0d, want %0d", n_samples, target);
    end
  endtask

  task automatic pulse_sync();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    m_sync_pend = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    step();
    n_checks++;
    if ({bus.dp_valid, bus.dp_phase, bus.dp_amp, bus.sample, bus.sample_valid,
         bus.busy, bus.overrun, bus.dbg_state} !== 50'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: dp_valid=%b phase=%h amp=%h sample=%h sv=%b busy=%b ovr=%b st=%0d, want all 0",
               bus.dp_valid, bus.dp_phase, bus.dp_amp, bus.sample, bus.sample_valid,
               bus.busy, bus.overrun, bus.dbg_state);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if ({bus.dp_valid, bus.busy, bus.sample_valid, bus.dbg_state} !== 5'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset: dp_valid=%b busy=%b sv=%b st=%0d, want 0 0 0 0",
               bus.dp_valid, bus.busy, bus.sample_valid, bus.dbg_state);
    end
  endtask

  task automatic test_basic();
    int n0;
    cfg_write(2'd0, 0, 16'h4000);
    cfg_write(2'd2, 0, 16'h0100);
    for (int k = 0; k < 3; k++) begin
      n0 = n_samples;
      start_sweep();
      wait_done(n0 + 1);
      step();
    end
  endtask

  task automatic test_timing();
    logic [2:0] got, want;
    start_sweep();
    for (int c = 1; c <= NCH + 3; c++) begin
      got  = {bus.dp_valid, bus.sample_valid, bus.busy};
      want = {c <= NCH, c == NCH + 2, c <= NCH + 2};
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL timing_c%0d: {dp_valid,sample_valid,busy}=%b, want %b", c, got, want);
      end
      step();
    end
  endtask

  task automatic test_multi();
    int a, n0;
    for (int i = 1; i < NCH; i++) begin
      a = int'($urandom_range(0, 8000)) - 4000;
      cfg_write(2'd0, i, a[15:0]);
      cfg_write(2'd2, i, 16'($urandom_range(0, 16'hFFFF)));
      cfg_write(2'd1, i, 16'($urandom_range(0, 16'hFFFF)));
    end
    for (int k = 0; k < 2; k++) begin
      n0 = n_samples;
      start_sweep();
      wait_done(n0 + 1);
      step();
    end
  endtask

  task automatic test_sync();
    int n0;
    cfg_write(2'd1, 3, 16'h8000);
    cfg_write(2'd2, 3, 16'h0230);
    cfg_write(2'd0, 3, 16'h1000);
    pulse_sync();
    pulse_sync();
    for (int k = 0; k < 2; k++) begin
      n0 = n_samples;
      start_sweep();
      wait_done(n0 + 1);
      step();
    end
  endtask

  task automatic test_overrun();
    int n0;
    n0 = n_samples;
    start_sweep();
    step();
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b1) begin
      n_errors++;
      $display("FAIL overrun_pulse: overrun=%b, want 1", bus.overrun);
    end
    step();
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL overrun_width: overrun=%b, want 0", bus.overrun);
    end
    wait_done(n0 + 1);
    repeat (15) step();
    n_checks++;
    if (n_samples !== n0 + 1) begin
      n_errors++;
      $display("FAIL overrun_samples: samples=%0d, want %0d", n_samples, n0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = n_samples;
    start_sweep();
    repeat (NCH + 2) step();
    start_sweep();
    n_checks++;
    if ({bus.overrun, bus.busy} !== 2'b01) begin
      n_errors++;
      $display("FAIL b2b_accept: overrun=%b busy=%b, want 0 1", bus.overrun, bus.busy);
    end
    wait_done(n0 + 2);
    step();
  endtask

  task automatic test_saturation();
    int n0;
    force_mode = 1'b1;
    force_val  = 16'h7FFF;
    n0 = n_samples;
    start_sweep();
    wait_done(n0 + 1);
    n_checks++;
    if (bus.sample !== 16'h7FFF) begin
      n_errors++;
      $display("FAIL sat_pos: sample=%h, want 7fff", bus.sample);
    end
    step();
    force_val = 16'h8000;
    start_sweep();
    wait_done(n0 + 2);
    n_checks++;
    if (bus.sample !== 16'h8000) begin
      n_errors++;
      $display("FAIL sat_neg: sample=%h, want 8000", bus.sample);
    end
    step();
    force_mode = 1'b0;
  endtask

  task automatic test_mute();
    int n0;
    cfg_write(2'd3, 0, 16'h0001);
    n0 = n_samples;
    start_sweep();
    wait_done(n0 + 1);
    step();
    cfg_write(2'd3, 0, 16'h0000);
    for (int k = 0; k < 2; k++) begin
      start_sweep();
      wait_done(n0 + 2 + k);
      step();
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n0;
    start_sweep();
    repeat (4) step();
    n_checks++;
    if ({bus.dp_valid, bus.busy} !== 2'b11) begin
      n_errors++;
      $display("FAIL mid_sweep_active: dp_valid=%b busy=%b, want 1 1", bus.dp_valid, bus.busy);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.dp_valid, bus.dp_phase, bus.dp_amp, bus.sample, bus.sample_valid,
         bus.busy, bus.overrun, bus.dbg_state} !== 50'h0) begin
      n_errors++;
      $display("FAIL reset_mid_sweep: dp_valid=%b phase=%h amp=%h sample=%h sv=%b busy=%b ovr=%b st=%0d, want all 0",
               bus.dp_valid, bus.dp_phase, bus.dp_amp, bus.sample, bus.sample_valid,
               bus.busy, bus.overrun, bus.dbg_state);
    end
    exp_q.delete();
    exp_s_q.delete();
    model_reset();
    step();
    reset = 1'b0;
    step();
    cfg_write(2'd0, 0, 16'h4000);
    cfg_write(2'd2, 0, 16'h0100);
    n0 = n_samples;
    for (int k = 0; k < 2; k++) begin
      start_sweep();
      wait_done(n0 + 1 + k);
      step();
    end
  endtask

  initial begin
    bus.cfg_we      = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_sel     = 2'd0;
    bus.cfg_data    = 16'h0000;
    bus.sync        = 1'b0;
    bus.sample_tick = 1'b0;

    test_reset();
    test_basic();
    test_timing();
    test_multi();
    test_sync();
    test_overrun();
    test_back_to_back();
    test_saturation();
`ifdef WAVESEQ_MUTE_EN
    test_mute();
`else
    // Without the mute register a cfg_sel=3 write must leave voice 0 audible.
    cfg_write(2'd3, 0, 16'h0001);
    begin
      int n0;
      n0 = n_samples;
      start_sweep();
      wait_done(n0 + 1);
      step();
    end
`endif
    test_reset_mid_sweep();

    n_checks++;
    if (exp_q.size() != 0 || exp_s_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain: requests left=%0d samples left=%0d, want 0 0",
               exp_q.size(), exp_s_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end
endmodule
